cascade_counter_bank: RTL and testbench

- Parametrised bank of CH cascaded modulo-MODULUS counters, each WIDTH bits wide. Stage 0 is least significant; each higher stage advances when every lower stage wraps.
- Supports free-run (prescaled), manual single-step from a pushbutton, up/down direction, per-stage synchronous load, and a wrap/borrow pulse.
- Successor to the fixed 5/4/3-bit switch/key counter in the final project. Feeds the LED and 7-segment display logic.

---
 rtl/cascade_counter_bank.sv | 132 +++++++++++++
 tb/tb_cascade_counter_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cascade_counter_bank.sv
// cascade_counter_bank: a bank of CH cascaded modulo-MODULUS counters.
// Stage 0 is least significant. The bank advances from a prescaled
// free-run tick or, while stopped, from a debounced-by-sync pushbutton step.
// Supports up/down counting, a clamped per-stage load, and a carry pulse
// after a full-bank wrap.

module cascade_stage #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 24
) (
    input  logic             ck,
    input  logic             clr,
    input  logic             ctrl,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt,
    output logic             term
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    // Terminal value depends on direction: top of range going up, zero going down.
    assign term = ctrl ? (cnt == '0) : (cnt == MAXV);

    // Load wins over advance; advance wraps within 0..MODULUS-1.
    always_ff @(posedge ck or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en) begin
            if (ctrl) cnt <= (cnt == '0)  ? MAXV : cnt - WIDTH'(1);
            else      cnt <= (cnt == MAXV) ? '0  : cnt + WIDTH'(1);
        end
    end
endmodule

module cascade_counter_bank #(
    parameter  int CH      = 3,
    parameter  int WIDTH   = 5,
    parameter  int MODULUS = 24,
    parameter  int DIV     = 4,
    localparam int SELW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                ck,
    input  logic                clr,
    input  logic                stop,
    input  logic                ctrl,
    input  logic                load,
    input  logic [SELW-1:0]     load_sel,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                key_n,
    output logic [CH*WIDTH-1:0] count,
    output logic                carry,
    output logic                running
);
    localparam int               PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PLAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);

    logic [PW-1:0]               psc;
    logic                        tick;
    logic                        s1, s2, p;
    logic                        step;
    logic                        adv;
    logic                        adv_eff;
    logic [WIDTH-1:0]            ld_clamp;
    logic [CH-1:0]               en;
    logic [CH-1:0]               ld_hit;
    logic [CH-1:0]               term;
    logic [CH-1:0][WIDTH-1:0]    cnt;

    // Prescaler runs only while free-running and holds its phase when stopped.
    always_ff @(posedge ck or posedge clr) begin
        if (clr)        psc <= '0;
        else if (!stop) psc <= (psc == PLAST) ? '0 : psc + PW'(1);
    end

    assign tick = !stop && (psc == PLAST);

    // Two-flop synchroniser plus a history flop for falling-edge detection;
    // all idle high so reset never fabricates a step.
    always_ff @(posedge ck or posedge clr) begin
        if (clr) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            p  <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign step     = p & ~s2;
    assign adv      = tick | (step & stop);
    // A load in the same cycle swallows the advance entirely.
    assign adv_eff  = adv & ~load;
    assign ld_clamp = (load_val > MAXV) ? MAXV : load_val;

    for (genvar k = 0; k < CH; k++) begin : g_stage
        assign ld_hit[k] = load && (load_sel == SELW'(k));
        if (k == 0) begin : g_lsb
            assign en[k] = adv_eff;
        end else begin : g_upper
            assign en[k] = adv_eff & (&term[k-1:0]);
        end
        cascade_stage #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_stage (
            .ck     (ck),
            .clr    (clr),
            .ctrl   (ctrl),
            .en     (en[k]),
            .ld     (ld_hit[k]),
            .ld_val (ld_clamp),
            .cnt    (cnt[k]),
            .term   (term[k])
        );
    end

    assign count = cnt;

    // Carry flags an advance that rolled every stage; running mirrors stop.
    always_ff @(posedge ck or posedge clr) begin
        if (clr) begin
            carry   <= 1'b0;
            running <= 1'b0;
        end else begin
            carry   <= adv_eff & (&term);
            running <= ~stop;
        end
    end
endmodule

// File: tb/tb_cascade_counter_bank.sv
// Directed bench for cascade_counter_bank at CH=3, WIDTH=5, MODULUS=24, DIV=4.
// count packs as {stage2, stage1, stage0}, 5 bits each.

module tb_cascade_counter_bank;
    logic        ck = 1'b0;
    logic        clr = 1'b1;
    logic        stop = 1'b0;
    logic        ctrl = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  load_sel = '0;
    logic [4:0]  load_val = '0;
    logic        key_n = 1'b1;
    logic [14:0] count;
    logic        carry;
    logic        running;

    int checks = 0;
    int errors = 0;
    logic carry_seen;

    cascade_counter_bank #(.CH(3), .WIDTH(5), .MODULUS(24), .DIV(4)) dut (
        .ck       (ck),
        .clr      (clr),
        .stop     (stop),
        .ctrl     (ctrl),
        .load     (load),
        .load_sel (load_sel),
        .load_val (load_val),
        .key_n    (key_n),
        .count    (count),
        .carry    (carry),
        .running  (running)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    // Reset pulse spanning one edge; released just after that edge.
    task automatic do_reset(input logic stop_v);
        clr  = 1'b1;
        stop = stop_v;
        ctrl = 1'b0;
        load = 1'b0;
        key_n = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic load_stage(input logic [1:0] sel, input logic [4:0] val);
        load = 1'b1;
        load_sel = sel;
        load_val = val;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        // 1: free-run then async mid-cycle reset
        do_reset(1'b0);
        chk("rst_count", 32'(count), 0);
        chk("rst_carry", 32'(carry), 0);
        chk("rst_running", 32'(running), 0);
        cyc(10);
        chk("t1_run10", 32'(count), 2);
        chk("t1_running", 32'(running), 1);
        #2 clr = 1'b1;
        #1;
        chk("t1_async_count", 32'(count), 0);
        chk("t1_async_carry", 32'(carry), 0);
        chk("t1_async_running", 32'(running), 0);
        #1 clr = 1'b0;

        // 2: free-run up, 96 cycles
        do_reset(1'b0);
        carry_seen = 1'b0;
        cyc(4);
        chk("t2_first_tick", 32'(count), 1);
        for (int i = 0; i < 88; i++) begin
            cyc(1);
            if (carry) carry_seen = 1'b1;
        end
        chk("t2_at92", 32'(count), 23);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (carry) carry_seen = 1'b1;
        end
        chk("t2_at96", 32'(count), 32);
        chk("t2_nocarry", 32'(carry_seen), 0);

        // 3: full wrap up
        do_reset(1'b1);
        load_stage(2'd0, 5'd23);
        load_stage(2'd1, 5'd23);
        load_stage(2'd2, 5'd23);
        stop = 1'b0;
        cyc(3);
        chk("t3_preload", 32'(count), 24311);
        chk("t3_precarry", 32'(carry), 0);
        cyc(1);
        chk("t3_wrap", 32'(count), 0);
        chk("t3_carry", 32'(carry), 1);
        cyc(1);
        chk("t3_carry_drop", 32'(carry), 0);

        // 4: down borrow then up wrap
        do_reset(1'b0);
        ctrl = 1'b1;
        cyc(4);
        chk("t4_borrow", 32'(count), 24311);
        chk("t4_borrow_carry", 32'(carry), 1);
        ctrl = 1'b0;
        cyc(1);
        chk("t4_carry_drop", 32'(carry), 0);
        chk("t4_hold", 32'(count), 24311);
        cyc(3);
        chk("t4_upwrap", 32'(count), 0);
        chk("t4_upwrap_carry", 32'(carry), 1);

        // 5: manual step, held key gives one step
        do_reset(1'b1);
        key_n = 1'b0;
        cyc(2);
        chk("t5_before_step", 32'(count), 0);
        cyc(1);
        chk("t5_step", 32'(count), 1);
        cyc(17);
        chk("t5_held", 32'(count), 1);
        chk("t5_running", 32'(running), 0);
        key_n = 1'b1;
        cyc(4);
        chk("t5_release", 32'(count), 1);
        // key ignored while free-running
        do_reset(1'b0);
        key_n = 1'b0;
        cyc(20);
        chk("t5_freerun_key", 32'(count), 5);
        key_n = 1'b1;

        // 6: load edge cases
        do_reset(1'b1);
        load_stage(2'd1, 5'd30);
        chk("t6_clamp", 32'(count), 736);
        load_stage(2'd3, 5'd5);
        chk("t6_sel_oob", 32'(count), 736);
        load_stage(2'd0, 5'd23);
        chk("t6_ld0", 32'(count), 759);
        stop = 1'b0;
        cyc(3);
        chk("t6_pre_tick", 32'(count), 759);
        load_stage(2'd2, 5'd5);
        chk("t6_ld_in_tick", 32'(count), 5879);
        chk("t6_ld_nocarry", 32'(carry), 0);
        cyc(1);
        chk("t6_after", 32'(count), 5879);
        chk("t6_after_carry", 32'(carry), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
